mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous up/down modulo counter with built-in prescaler, parallel load and terminal-count strobe. Generalises the 3-bit T-flip-flop ripple-carry counter and fixed divide-by-4 clock divider into one single-clock block. The prescaler produces a count-enable strobe instead of a derived clock. Used wherever the design needs a programmable-length count or a slow periodic event from the system clock.

## Interface
- WIDTH, 3: counter width in bits; requires MODULUS <= 2**WIDTH.
- MODULUS, 8: count range 0..MODULUS-1; requires MODULUS >= 2.
- DIV, 1: prescale ratio; the counter steps once per DIV enabled cycles; requires DIV >= 1.

- clk  in  1  system clock; all state changes on the rising edge.
- RSTN  in  1  reset; asynchronous and active-low.
- en  in  1  count enable; gates the prescaler and the counter.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled at the stepping edge.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- Q  out  WIDTH  current count (registered).
- tick  out  1  combinational step strobe: en & (prescaler == DIV-1) & ~load.
- tc  out  1  registered terminal-count pulse, one cycle wide.

## Operation
- Reset (RSTN=0, any time, no clock needed): Q=0, prescaler=0, tc=0. tick is 0 because the prescaler is 0 and DIV>1. When DIV=1, tick follows en.
- Priority per rising edge: load > en > hold.
- load=1: Q <= load_val.
  - If load_val >= MODULUS, Q <= MODULUS-1 (clamp).
  - Prescaler <= 0, tc <= 0. Applies regardless of en.
- en=1, load=0: prescaler counts 0..DIV-1 and wraps to 0. On the edge where tick=1, Q steps once in direction up.
- Up step: Q=MODULUS-1 -> 0 with tc <= 1; otherwise Q+1.
- Down step: Q=0 -> MODULUS-1 with tc <= 1; otherwise Q-1.
- tc <= 0 on every edge that is not a boundary step.
- en=0: prescaler and Q hold, and tc <= 0. Re-enabling resumes from the held prescaler phase.
- Changing up between ticks has no effect until the next tick edge.
- Arithmetic is modulo MODULUS, not 2**WIDTH. Values >= MODULUS are never reachable.

## Timing
- Latency from load to Q: 1 edge. Latency from tick to Q update: same edge.
- tc asserts on the same edge as the boundary step, aligned with the new Q, for exactly one cycle per boundary event.
- With en held high, Q steps every DIV cycles. The first step occurs DIV edges after reset release or load.
- Async reset asserted mid-count clears immediately. The first count edge comes after RSTN deasserts.

## Configuration
- COUNTER_SAT_EN defined: the counter saturates instead of wrapping.
  - Up at MODULUS-1 holds Q=MODULUS-1; down at 0 holds Q=0.
  - tc pulses on each blocked tick, one cycle per tick.
  - The prescaler still runs.
- COUNTER_SAT_EN undefined: wrap-around behaviour as described in Operation.

## Test plan
- Async reset: run with WIDTH=3, MODULUS=8, DIV=1, count to Q=5, then drop RSTN between edges -> Q=0 and tc=0 immediately, without a clock edge.
- Up wrap: MODULUS=8, DIV=1, en=1, up=1 from reset -> Q goes 1..7,0. tc=1 only in the cycle Q=0, and it recurs every 8 cycles.
- Prescale plus down count: MODULUS=10, WIDTH=4, DIV=3, up=0 -> tick every 3rd cycle, Q goes 9,8,... Tc pulses with the 0->9 step. Dropping en for 5 cycles freezes Q and the prescaler phase.
- Load: load_val=5 -> Q=5 next edge and the prescaler restarts. Load_val=12 with MODULUS=10 -> Q=9. Load and tick in the same cycle -> load wins and tc=0.
- Direction change: flip up between ticks with DIV=4 -> only the direction present at the tick edge is applied.
- COUNTER_SAT_EN: up from Q=7 with MODULUS=8 -> Q stays 7 with a tc pulse every tick. Down from 0 -> Q stays 0 with a tc pulse every tick.

Source files
------------

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: the controller (master) drives
// the enable, direction and load signals; the counter (slave) returns the count and strobes.
interface mod_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tick;
  logic             tc;

  modport master (
    output en, up, load, load_val,
    input  Q, tick, tc
  );

  modport slave (
    input  en, up, load, load_val,
    output Q, tick, tc
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down modulo-MODULUS counter with a DIV-cycle prescaler, clamped parallel load and terminal-count pulse.
// Define COUNTER_SAT_EN to make the counter saturate at the range ends instead of wrapping.
module mod_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int DIV     = 1
) (
  input logic clk,
  input logic RSTN,
  mod_updown_counter_if.slave bus
);

  localparam int                PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]     PS_LAST = PW'(DIV - 1);
  localparam logic [WIDTH-1:0]  Q_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]    MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [PW-1:0]    ps_p0;
  logic [WIDTH-1:0] q_p0;
  logic             tc_p0;
  logic             tick_c;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return ({1'b0, v} >= MOD_EXT) ? Q_MAX : v;
  endfunction

  function automatic logic at_bound(input logic [WIDTH-1:0] q, input logic dir);
    return dir ? (q == Q_MAX) : (q == '0);
  endfunction

  // A boundary step either wraps or is blocked; tc fires in both cases.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] q, input logic dir);
    if (at_bound(q, dir)) begin
`ifdef COUNTER_SAT_EN
      return q;
`else
      return dir ? '0 : Q_MAX;
`endif
    end
    return dir ? q + 1'b1 : q - 1'b1;
  endfunction

  function automatic logic [PW-1:0] ps_next(input logic [PW-1:0] ps);
    return (ps == PS_LAST) ? '0 : ps + 1'b1;
  endfunction

  assign tick_c = bus.en & (ps_p0 == PS_LAST) & ~bus.load;

  // Stage p0: prescaler phase, count and terminal-count register
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      ps_p0 <= '0;
      q_p0  <= '0;
      tc_p0 <= 1'b0;
    end else if (bus.load) begin
      ps_p0 <= '0;
      q_p0  <= clamp_load(bus.load_val);
      tc_p0 <= 1'b0;
    end else if (bus.en) begin
      ps_p0 <= ps_next(ps_p0);
      if (tick_c) begin
        q_p0  <= step(q_p0, bus.up);
        tc_p0 <= at_bound(q_p0, bus.up);
      end else begin
        tc_p0 <= 1'b0;
      end
    end else begin
      tc_p0 <= 1'b0;
    end
  end

  assign bus.Q    = q_p0;
  assign bus.tc   = tc_p0;
  assign bus.tick = tick_c;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: three instances (M8/D1, M10/D3, M8/D4) sharing clock and reset.
module tb_mod_updown_counter;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk  = 1'b0;
  logic RSTN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(3)) ia ();
  mod_updown_counter_if #(.WIDTH(4)) ib ();
  mod_updown_counter_if #(.WIDTH(3)) ic ();

  mod_updown_counter #(.WIDTH(3), .MODULUS(8),  .DIV(1)) dut_a (.clk(clk), .RSTN(RSTN), .bus(ia));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV(3)) dut_b (.clk(clk), .RSTN(RSTN), .bus(ib));
  mod_updown_counter #(.WIDTH(3), .MODULUS(8),  .DIV(4)) dut_c (.clk(clk), .RSTN(RSTN), .bus(ic));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nedge(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    ia.en = 1'b0; ia.up = 1'b1; ia.load = 1'b0; ia.load_val = '0;
    ib.en = 1'b0; ib.up = 1'b1; ib.load = 1'b0; ib.load_val = '0;
    ic.en = 1'b0; ic.up = 1'b1; ic.load = 1'b0; ic.load_val = '0;

    // reset state
    nedge(1);
    check("rst_a_q", ia.Q, 0);
    check("rst_a_tc", ia.tc, 0);
    check("rst_a_tick", ia.tick, 0);
    check("rst_b_q", ib.Q, 0);
    check("rst_b_tick", ib.tick, 0);
    ia.en = 1'b1;
    RSTN  = 1'b1;
    #1 check("a_tick_follows_en", ia.tick, 1);

    // up count from reset, wrap (or saturate) at 7
    for (int i = 1; i <= 7; i++) begin
      nedge(1);
      check("a_up_q", ia.Q, i);
      check("a_up_tc", ia.tc, 0);
    end
    nedge(1);
    check("a_wrap_q", ia.Q, SAT ? 7 : 0);
    check("a_wrap_tc", ia.tc, 1);
    nedge(1);
    check("a_after_wrap_q", ia.Q, SAT ? 7 : 1);
    check("a_after_wrap_tc", ia.tc, SAT ? 1 : 0);
    nedge(7);
    check("a_wrap2_q", ia.Q, SAT ? 7 : 0);
    check("a_wrap2_tc", ia.tc, 1);

    // down step at 0
    ia.load = 1'b1; ia.load_val = 3'd0;
    nedge(1);
    check("a_load0_q", ia.Q, 0);
    check("a_load0_tc", ia.tc, 0);
    ia.load = 1'b0; ia.up = 1'b0;
    nedge(1);
    check("a_down_wrap_q", ia.Q, SAT ? 0 : 7);
    check("a_down_wrap_tc", ia.tc, 1);
    nedge(1);
    check("a_down_next_q", ia.Q, SAT ? 0 : 6);
    check("a_down_next_tc", ia.tc, SAT ? 1 : 0);

    // async reset between edges at Q=5
    ia.load = 1'b1; ia.load_val = 3'd3; ia.up = 1'b1;
    nedge(1);
    ia.load = 1'b0;
    nedge(2);
    check("a_pre_rst_q", ia.Q, 5);
    #2 RSTN = 1'b0;
    #1 check("a_async_rst_q", ia.Q, 0);
    check("a_async_rst_tc", ia.tc, 0);
    nedge(1);
    RSTN = 1'b1;
    ia.load = 1'b1; ia.load_val = 3'd1; ia.up = 1'b0;
    nedge(1);
    ia.load = 1'b0;
    nedge(2);
    check("a_pre_rst2_tc", ia.tc, 1);
    check("a_pre_rst2_q", ia.Q, SAT ? 0 : 7);
    #2 RSTN = 1'b0;
    #1 check("a_async_rst2_q", ia.Q, 0);
    check("a_async_rst2_tc", ia.tc, 0);
    nedge(1);
    RSTN  = 1'b1;
    ia.en = 1'b0;
    nedge(1);
    check("a_hold_after_rst_q", ia.Q, 0);

    // prescaled down count, DIV=3, MODULUS=10
    ib.en = 1'b1; ib.up = 1'b0;
    nedge(2);
    check("b_tick_phase2", ib.tick, 1);
    check("b_q_before_tick", ib.Q, 0);
    nedge(1);
    check("b_down_wrap_q", ib.Q, SAT ? 0 : 9);
    check("b_down_wrap_tc", ib.tc, 1);
    nedge(1);
    check("b_tick_phase0", ib.tick, 0);
    check("b_tc_clear", ib.tc, 0);
    nedge(2);
    check("b_down_q", ib.Q, SAT ? 0 : 8);
    check("b_down_tc", ib.tc, SAT ? 1 : 0);
    nedge(1);
    ib.en = 1'b0;
    nedge(5);
    check("b_frozen_q", ib.Q, SAT ? 0 : 8);
    check("b_frozen_tc", ib.tc, 0);
    check("b_frozen_tick", ib.tick, 0);
    ib.en = 1'b1;
    #1 check("b_resume_phase1_tick", ib.tick, 0);
    nedge(1);
    check("b_resume_phase2_tick", ib.tick, 1);
    nedge(1);
    check("b_resume_q", ib.Q, SAT ? 0 : 7);
    check("b_resume_tc", ib.tc, SAT ? 1 : 0);

    // parallel load, clamp, and load beating tick
    ib.load = 1'b1; ib.load_val = 4'd5;
    nedge(1);
    check("b_load5_q", ib.Q, 5);
    check("b_load5_tc", ib.tc, 0);
    ib.load = 1'b0; ib.up = 1'b1;
    nedge(2);
    check("b_load_restart_q", ib.Q, 5);
    nedge(1);
    check("b_load_first_step_q", ib.Q, 6);
    ib.load = 1'b1; ib.load_val = 4'd12;
    nedge(1);
    check("b_load_clamp_q", ib.Q, 9);
    ib.load = 1'b0;
    nedge(2);
    check("b_tick_at_max", ib.tick, 1);
    ib.load = 1'b1; ib.load_val = 4'd3;
    #1 check("b_tick_masked_by_load", ib.tick, 0);
    nedge(1);
    check("b_load_wins_q", ib.Q, 3);
    check("b_load_wins_tc", ib.tc, 0);
    ib.load = 1'b0;
    nedge(2);
    check("b_post_load_hold_q", ib.Q, 3);
    nedge(1);
    check("b_post_load_step_q", ib.Q, 4);

    // direction sampled only at the tick edge, DIV=4
    ic.load = 1'b1; ic.load_val = 3'd4;
    nedge(1);
    check("c_load_q", ic.Q, 4);
    ic.load = 1'b0; ic.en = 1'b1; ic.up = 1'b1;
    nedge(1); ic.up = 1'b0;
    nedge(1); ic.up = 1'b1;
    nedge(1); ic.up = 1'b0;
    check("c_before_tick_q", ic.Q, 4);
    check("c_tick_phase3", ic.tick, 1);
    nedge(1);
    check("c_down_step_q", ic.Q, 3);
    check("c_down_step_tc", ic.tc, 0);
    nedge(3);
    check("c_hold_between_q", ic.Q, 3);
    ic.up = 1'b1;
    nedge(1);
    check("c_up_step_q", ic.Q, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
